// File: rtl/bus_hub_n_pl_pkg.sv
// Shared types and defaults for the N-port pipelined bus hub.
package bus_hub_n_pl_pkg;

   typedef enum logic [1:0] {IDLE, DECODE, ACCESS, RESP} hub_state_t;

   typedef enum logic {OP_READ, OP_WRITE} op_t;

   // Wide zero constant, sliced down to DW to form the default error read data.
   localparam int MAX_DW = 1024;
   localparam logic [MAX_DW-1:0] DEF_ERR_RDATA = '0;

   // The binary index needs at least one bit, even for a single-device hub.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bus_hub_n_pl_if.sv
// Host-side and device-side signals of the hub.
// The slave view belongs to the hub; the master view belongs to the host plus devices.
interface bus_hub_n_pl_if #(
   parameter int N_DEV = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
);
   localparam int MW = DW / 8;

   logic [AW-1:0]         host_address;
   logic [DW-1:0]         host_data_write;
   logic [MW-1:0]         host_write_mask;
   logic                  host_wen;
   logic                  host_ren;
   logic [DW-1:0]         host_data_read;
   logic                  host_ready;
   logic                  host_error;

   logic [N_DEV*AW-1:0]   device_address;
   logic [N_DEV*DW-1:0]   device_data_write;
   logic [N_DEV*MW-1:0]   device_write_mask;
   logic [N_DEV-1:0]      device_wen;
   logic [N_DEV-1:0]      device_ren;
   logic [N_DEV-1:0]      device_ready;
   logic [N_DEV*DW-1:0]   device_data_read;
   logic [N_DEV-1:0]      device_active;

   modport slave (
      input  host_address, host_data_write, host_write_mask, host_wen, host_ren,
      output host_data_read, host_ready, host_error,
      output device_address, device_data_write, device_write_mask, device_wen, device_ren,
      input  device_ready, device_data_read, device_active
   );

   modport master (
      output host_address, host_data_write, host_write_mask, host_wen, host_ren,
      input  host_data_read, host_ready, host_error,
      input  device_address, device_data_write, device_write_mask, device_wen, device_ren,
      output device_ready, device_data_read, device_active
   );

endinterface

// File: rtl/bus_hub_n_pl_prio_onehot.sv
// Lowest-index priority picker: one-hot grant, binary index and an any-set flag.
module prio_onehot
   import bus_hub_n_pl_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] index,
   output logic          any
);

   // Scan upward and keep only the first set bit so the lowest index wins.
   always_comb begin
      onehot = '0;
      index  = '0;
      any    = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (req[i] && !any) begin
            onehot[i] = 1'b1;
            index     = IW'(i);
            any       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_hub_n_pl.sv
// N-port pipelined bus hub: one host, N memory-mapped devices, with unmapped and timeout errors.
module bus_hub_n_pl
   import bus_hub_n_pl_pkg::*;
#(
   parameter int              N_DEV     = 4,
   parameter int              AW        = 32,
   parameter int              DW        = 32,
   parameter int              TIMEOUT   = 255,
   parameter logic [DW-1:0]   ERR_RDATA = DEF_ERR_RDATA[DW-1:0]
) (
   input  logic               clk,
   input  logic               rst_,
   bus_hub_n_pl_if.slave      bus
);

   localparam int MW = DW / 8;
   localparam int IW = idx_width(N_DEV);
   localparam int TW = $clog2(TIMEOUT + 1);

   hub_state_t          state;
   hub_state_t          next_state;

   logic [AW-1:0]       req_addr;
   logic [DW-1:0]       req_wdata;
   logic [MW-1:0]       req_mask;
   op_t                 req_op;

   logic [N_DEV-1:0]    dec_oh;
   logic [IW-1:0]       dec_idx;
   logic                dec_any;
   logic [N_DEV-1:0]    sel_oh;
   logic [IW-1:0]       sel_idx;

   logic [TW-1:0]       timer;
   logic [DW-1:0]       resp_data;
   logic                resp_err;

   logic                host_req;
   logic                sel_ready;
   logic                timeout_hit;

   assign host_req    = bus.host_wen | bus.host_ren;
   assign sel_ready   = bus.device_ready[sel_idx];
   assign timeout_hit = (timer == TW'(TIMEOUT - 1));

   prio_onehot #(.N(N_DEV), .IW(IW)) u_prio (
      .req    (bus.device_active),
      .onehot (dec_oh),
      .index  (dec_idx),
      .any    (dec_any)
   );

   // State register; the async reset drops the FSM, and with it every strobe, at once.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state decode; a ready on the selected port takes priority over the timeout.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (host_req) next_state = DECODE;
         DECODE:  next_state = dec_any ? ACCESS : RESP;
         ACCESS:  if (sel_ready || timeout_hit) next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs: broadcast request regs, strobe only the selected port, respond from registers.
   always_comb begin
      bus.host_ready        = (state == RESP);
      bus.host_error        = (state == RESP) && resp_err;
      bus.host_data_read    = resp_data;
      bus.device_address    = {N_DEV{req_addr}};
      bus.device_data_write = {N_DEV{req_wdata}};
      bus.device_write_mask = {N_DEV{req_mask}};
      bus.device_wen        = '0;
      bus.device_ren        = '0;
      if (state == ACCESS) begin
         if (req_op == OP_WRITE) bus.device_wen = sel_oh;
         else                    bus.device_ren = sel_oh;
      end
   end

   // Capture the host request once; the host may change its inputs afterwards without effect.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         req_addr  <= '0;
         req_wdata <= '0;
         req_mask  <= '0;
         req_op    <= OP_READ;
      end else if (state == IDLE && host_req) begin
         req_addr  <= bus.host_address;
         req_wdata <= bus.host_data_write;
         req_mask  <= bus.host_write_mask;
         req_op    <= bus.host_wen ? OP_WRITE : OP_READ;
      end
   end

   // Lock the decoded device in DECODE and count ACCESS cycles toward the timeout.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         sel_oh  <= '0;
         sel_idx <= '0;
         timer   <= '0;
      end else if (state == DECODE) begin
         sel_oh  <= dec_oh;
         sel_idx <= dec_idx;
         timer   <= '0;
      end else if (state == ACCESS) begin
         timer   <= timer + TW'(1);
      end
   end

   // Response registers; read data persists after RESP until the next response overwrites it.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         resp_data <= '0;
         resp_err  <= 1'b0;
      end else if (state == DECODE && !dec_any) begin
         resp_data <= ERR_RDATA;
         resp_err  <= 1'b1;
      end else if (state == ACCESS) begin
         if (sel_ready) begin
            resp_err  <= 1'b0;
            resp_data <= (req_op == OP_READ) ? bus.device_data_read[int'(sel_idx)*DW +: DW] : '0;
         end else if (timeout_hit) begin
            resp_err  <= 1'b1;
            resp_data <= ERR_RDATA;
         end
      end
   end

endmodule

// File: tb/tb_bus_hub_n_pl.sv
// Directed self-checking bench for bus_hub_n_pl with four devices and an 8-cycle timeout.
module tb_bus_hub_n_pl;

   localparam int N_DEV   = 4;
   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int TIMEOUT = 8;

   logic clk;
   logic rst_;
   int   vectors;
   int   miscompares;

   bus_hub_n_pl_if #(.N_DEV(N_DEV), .AW(AW), .DW(DW)) bus ();

   bus_hub_n_pl #(
      .N_DEV   (N_DEV),
      .AW      (AW),
      .DW      (DW),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk  (clk),
      .rst_ (rst_),
      .bus  (bus.slave)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare one observed value against its hand-computed expectation.
   task automatic check_output(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Place a new host request on the bus.
   task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] mask, input logic wen, input logic ren);
      bus.host_address    = addr;
      bus.host_data_write = wdata;
      bus.host_write_mask = mask;
      bus.host_wen        = wen;
      bus.host_ren        = ren;
   endtask

   // Linear directed sequence.
   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_        = 1'b0;
      apply_stimulus(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
      bus.device_ready     = '0;
      bus.device_active    = '0;
      bus.device_data_read = '0;

      #2;
      check_output("rst_host_ready", bus.host_ready, 1'b0);
      check_output("rst_host_error", bus.host_error, 1'b0);
      check_output("rst_rdata", bus.host_data_read, 32'h0);
      check_output("rst_dev_wen", bus.device_wen, 4'b0000);
      check_output("rst_dev_ren", bus.device_ren, 4'b0000);
      check_output("rst_dev_addr", bus.device_address, 128'h0);
      tick();
      tick();
      rst_ = 1'b1;

      $display("[TB] write to dev0, ready one cycle after strobe");
      apply_stimulus(32'h0000_0010, 32'hCAFE_F00D, 4'b0011, 1'b1, 1'b0);
      bus.device_active = 4'b0001;
      tick();
      check_output("wr_decode_wen", bus.device_wen, 4'b0000);
      check_output("wr_dev_addr", bus.device_address, {4{32'h0000_0010}});
      tick();
      check_output("wr_access_wen", bus.device_wen, 4'b0001);
      check_output("wr_access_ren", bus.device_ren, 4'b0000);
      check_output("wr_dev_wdata", bus.device_data_write, {4{32'hCAFE_F00D}});
      check_output("wr_dev_mask", bus.device_write_mask, 16'h3333);
      tick();
      check_output("wr_wait_wen", bus.device_wen, 4'b0001);
      check_output("wr_wait_ready", bus.host_ready, 1'b0);
      bus.device_ready = 4'b0001;
      tick();
      check_output("wr_resp_ready", bus.host_ready, 1'b1);
      check_output("wr_resp_error", bus.host_error, 1'b0);
      check_output("wr_resp_rdata", bus.host_data_read, 32'h0);
      check_output("wr_resp_wen", bus.device_wen, 4'b0000);
      apply_stimulus(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
      bus.device_ready = '0;
      tick();
      check_output("wr_idle_ready", bus.host_ready, 1'b0);

      $display("[TB] read from dev2 with combinational ready");
      apply_stimulus(32'h0000_2000, 32'h0, 4'h0, 1'b0, 1'b1);
      bus.device_active    = 4'b0100;
      bus.device_ready     = 4'b0100;
      bus.device_data_read = {32'h3333_3333, 32'h1234_5678, 32'h1111_1111, 32'hDEAD_BEEF};
      tick();
      tick();
      check_output("rd_access_ren", bus.device_ren, 4'b0100);
      check_output("rd_access_wen", bus.device_wen, 4'b0000);
      check_output("rd_access_ready", bus.host_ready, 1'b0);
      tick();
      check_output("rd_resp_ready", bus.host_ready, 1'b1);
      check_output("rd_resp_rdata", bus.host_data_read, 32'h1234_5678);
      check_output("rd_resp_error", bus.host_error, 1'b0);
      apply_stimulus(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
      bus.device_ready = '0;
      tick();
      check_output("rd_hold_rdata", bus.host_data_read, 32'h1234_5678);
      check_output("rd_idle_ready", bus.host_ready, 1'b0);

      $display("[TB] unmapped address");
      apply_stimulus(32'h0000_9000, 32'h0, 4'h0, 1'b0, 1'b1);
      bus.device_active = 4'b0000;
      tick();
      check_output("um_decode_ren", bus.device_ren, 4'b0000);
      tick();
      check_output("um_resp_ready", bus.host_ready, 1'b1);
      check_output("um_resp_error", bus.host_error, 1'b1);
      check_output("um_resp_rdata", bus.host_data_read, 32'h0);
      check_output("um_resp_ren", bus.device_ren, 4'b0000);
      apply_stimulus(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
      tick();
      check_output("um_idle_error", bus.host_error, 1'b0);

      $display("[TB] dev1 never ready, timeout");
      apply_stimulus(32'h0000_1000, 32'h0, 4'h0, 1'b0, 1'b1);
      bus.device_active = 4'b0010;
      bus.device_ready  = 4'b0000;
      tick();
      for (int k = 0; k < TIMEOUT; k++) begin
         tick();
         check_output($sformatf("to_strobe_%0d", k), bus.device_ren, 4'b0010);
         check_output($sformatf("to_noready_%0d", k), bus.host_ready, 1'b0);
      end
      tick();
      check_output("to_resp_ready", bus.host_ready, 1'b1);
      check_output("to_resp_error", bus.host_error, 1'b1);
      check_output("to_resp_rdata", bus.host_data_read, 32'h0);
      check_output("to_resp_ren", bus.device_ren, 4'b0000);
      apply_stimulus(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
      tick();
      check_output("to_idle_ready", bus.host_ready, 1'b0);
      check_output("to_idle_error", bus.host_error, 1'b0);

      $display("[TB] dev1 and dev3 active, lowest index wins");
      apply_stimulus(32'h0000_3000, 32'h0, 4'h0, 1'b0, 1'b1);
      bus.device_active    = 4'b1010;
      bus.device_ready     = 4'b1000;
      bus.device_data_read = {32'hB3B3_B3B3, 32'h2222_2222, 32'hA1A1_A1A1, 32'h0000_0000};
      tick();
      tick();
      check_output("pr_access_ren", bus.device_ren, 4'b0010);
      tick();
      check_output("pr_ignore_ren", bus.device_ren, 4'b0010);
      check_output("pr_ignore_ready", bus.host_ready, 1'b0);
      bus.device_ready = 4'b1010;
      tick();
      check_output("pr_resp_ready", bus.host_ready, 1'b1);
      check_output("pr_resp_rdata", bus.host_data_read, 32'hA1A1_A1A1);
      check_output("pr_resp_error", bus.host_error, 1'b0);
      apply_stimulus(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
      bus.device_ready = '0;
      tick();

      $display("[TB] wen and ren together");
      apply_stimulus(32'h0000_0040, 32'h0102_0304, 4'hF, 1'b1, 1'b1);
      bus.device_active    = 4'b0001;
      bus.device_ready     = 4'b0001;
      bus.device_data_read = {32'h0, 32'h0, 32'h0, 32'h55AA_55AA};
      tick();
      tick();
      check_output("both_access_wen", bus.device_wen, 4'b0001);
      check_output("both_access_ren", bus.device_ren, 4'b0000);
      tick();
      check_output("both_resp_ready", bus.host_ready, 1'b1);
      check_output("both_resp_rdata", bus.host_data_read, 32'h0);
      apply_stimulus(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
      bus.device_ready = '0;
      tick();

      $display("[TB] reset during access");
      apply_stimulus(32'h0000_2004, 32'h0, 4'h0, 1'b0, 1'b1);
      bus.device_active    = 4'b0100;
      bus.device_ready     = 4'b0000;
      bus.device_data_read = {32'h0, 32'h0BAD_F00D, 32'h0, 32'h0};
      tick();
      tick();
      check_output("rs_access_ren", bus.device_ren, 4'b0100);
      #2;
      rst_ = 1'b0;
      #1;
      check_output("rs_async_ren", bus.device_ren, 4'b0000);
      check_output("rs_async_ready", bus.host_ready, 1'b0);
      tick();
      check_output("rs_held_ready", bus.host_ready, 1'b0);
      rst_ = 1'b1;
      bus.device_ready = 4'b0100;
      tick();
      check_output("rs_decode_ready", bus.host_ready, 1'b0);
      tick();
      check_output("rs_retry_ren", bus.device_ren, 4'b0100);
      tick();
      check_output("rs_retry_ready", bus.host_ready, 1'b1);
      check_output("rs_retry_rdata", bus.host_data_read, 32'h0BAD_F00D);
      apply_stimulus(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
      bus.device_ready = '0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
